// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider:
//   - FSM state encoding (IDLE / BUSY / DONE) as plain constants plus an enum
//     typedef built on them, so legacy code can compare against raw values.
//   - cnt_width_f(): width of the iteration counter for a given operand width.
// No ports (package).
// -----------------------------------------------------------------------------
package divider_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  // Counter must reach width-1; $clog2 of a width >= 2 is always >= 1.
  function automatic int cnt_width_f(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One combinational restoring-division iteration. The quotient register
// doubles as the dividend shift register: its MSB is shifted into the partial
// remainder and the new quotient bit is shifted into its LSB.
// Ports:
//   r_i  [width_p-1:0]  current partial remainder
//   q_i  [width_p-1:0]  current quotient / remaining dividend bits
//   d_i  [width_p-1:0]  divisor
//   r_o  [width_p-1:0]  next partial remainder
//   q_o  [width_p-1:0]  next quotient / dividend bits
// -----------------------------------------------------------------------------
module divider_step #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0] r_i,
  input  logic [width_p-1:0] q_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] r_o,
  output logic [width_p-1:0] q_o
);

  logic [width_p:0] trial;

  // One extra bit so the borrow lands in the MSB.
  assign trial = {r_i, q_i[width_p-1]} - {1'b0, d_i};

  always_comb begin
    if (!trial[width_p]) begin
      // Subtraction fits: the result is below d, so it fits in width_p bits.
      r_o = trial[width_p-1:0];
      q_o = {q_i[width_p-2:0], 1'b1};
    end else begin
      // Restore: keep the shifted remainder unchanged.
      r_o = {r_i[width_p-2:0], q_i[width_p-1]};
      q_o = {q_i[width_p-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divider_seq.sv
// -----------------------------------------------------------------------------
// divider_seq
// Iterative unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on input and output. One operation in flight.
// Result appears width_p cycles after the accept edge; initiation interval is
// width_p+2 cycles when the consumer is always ready.
// Divide by zero naturally yields quot = all ones, rem = dividend.
//
// Optional feature (macro DIVIDER_SEQ_DBZ_EN): adds dbz_o and short-circuits
// divide-by-zero straight to DONE one cycle after accept.
//
// Ports:
//   clk_i      clock, rising edge
//   reset_n_i  synchronous active-low reset
//   valid_i    upstream operands valid
//   ready_o    block can accept operands (IDLE)
//   a_i        dividend, width_p bits
//   b_i        divisor, width_p bits
//   valid_o    result valid (DONE)
//   ready_i    downstream accepts result
//   quot_o     quotient, registered, holds last result
//   rem_o      remainder, registered, holds last result
//   dbz_o      (DIVIDER_SEQ_DBZ_EN only) result was a divide-by-zero
// -----------------------------------------------------------------------------
import divider_pkg::*;

module divider_seq #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [width_p-1:0] quot_o,
`ifdef DIVIDER_SEQ_DBZ_EN
  output logic [width_p-1:0] rem_o,
  output logic               dbz_o
`else
  output logic [width_p-1:0] rem_o
`endif
);

  localparam int CNT_W = cnt_width_f(width_p);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(width_p - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0] q_q, q_d;
  logic [width_p-1:0] r_q, r_d;
  logic [width_p-1:0] d_q, d_d;
  logic [width_p-1:0] quot_q, quot_d;
  logic [width_p-1:0] rem_q, rem_d;
  logic [width_p-1:0] step_r, step_q;
`ifdef DIVIDER_SEQ_DBZ_EN
  logic               dbz_q, dbz_d;
`endif

  divider_step #(
    .width_p(width_p)
  ) u_step (
    .r_i(r_q),
    .q_i(q_q),
    .d_i(d_q),
    .r_o(step_r),
    .q_o(step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIVIDER_SEQ_DBZ_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          q_d     = a_i;
          d_d     = b_i;
          r_d     = '0;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef DIVIDER_SEQ_DBZ_EN
          dbz_d = (b_i == '0);
          if (b_i == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = a_i;
          end
`endif
        end
      end
      BUSY: begin
        q_d   = step_q;
        r_d   = step_r;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Output registers only change here, so they hold through IDLE/BUSY.
          state_d = DONE;
          quot_d  = step_q;
          rem_d   = step_r;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
`ifdef DIVIDER_SEQ_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
`ifdef DIVIDER_SEQ_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign ready_o = (state_q == IDLE);
  assign valid_o = (state_q == DONE);
  assign quot_o  = quot_q;
  assign rem_o   = rem_q;
`ifdef DIVIDER_SEQ_DBZ_EN
  assign dbz_o   = dbz_q & valid_o;
`endif

endmodule
